mux_scan_sequencer: RTL and testbench
=====================================

MUX_SCAN_SEQUENCER -- requirements
Module: mux_scan_sequencer

Interface
REQ-001 The block SHALL have parameter SETTLE, default 0, legal range 0..3; it is the number of wait cycles after each select change before sampling.
REQ-002 Port clk SHALL be an input, 1 bit wide: the single clock; all state updates occur on its rising edge.
REQ-003 Port reset SHALL be an input, 1 bit wide: asynchronous, active-high reset.
REQ-004 Port start SHALL be an input, 1 bit wide: requests a scan; sampled only in IDLE.
REQ-005 Port abort SHALL be an input, 1 bit wide: synchronous cancel of a scan in progress.
REQ-006 Port first_sel SHALL be an input, 4 bits wide: first select value of the scan; captured when start is accepted.
REQ-007 Port count SHALL be an input, 5 bits wide: number of bits to scan; captured when start is accepted; 0 or any value above 16 is treated as 16.
REQ-008 Port bit_in SHALL be an input, 1 bit wide: the output of the downstream 16:1 bit multiplexer.
REQ-009 Port select SHALL be an output, 4 bits wide: registered select driven to that multiplexer.
REQ-010 Port busy SHALL be an output, 1 bit wide: high in SETTLE and SAMPLE.
REQ-011 Port done SHALL be an output, 1 bit wide: a one-cycle pulse, high only in DONE.
REQ-012 Port data_out SHALL be an output, 16 bits wide: the captured bits, where bit k holds the sample taken while select==k.

Function
REQ-013 The FSM SHALL have the states IDLE, SETTLE, SAMPLE and DONE; all outputs SHALL be registered or decoded from the state only.
REQ-014 IDLE with start=1 SHALL, at the edge:
- load select<=first_sel,
- load remaining<=effective count,
- clear data_out to 0,
- go to SETTLE if SETTLE>0, else to SAMPLE.
REQ-015 SETTLE SHALL hold select for exactly SETTLE cycles using a wait counter, then go to SAMPLE.
REQ-016 The edge leaving SAMPLE SHALL:
- set data_out[select]<=bit_in,
- set select<=select+1 modulo 16 (15 wraps to 0),
- decrement remaining,
- go to DONE if remaining was 1, else go to SETTLE (SETTLE>0) or stay in SAMPLE (SETTLE=0).
REQ-017 The done pulse SHALL become visible count_eff*(SETTLE+1) edges after the accepting start edge; DONE SHALL go unconditionally to IDLE after one cycle.
REQ-018 start while busy or in DONE SHALL be ignored; no queuing.
REQ-019 abort=1 in SETTLE or SAMPLE SHALL return to IDLE at the next edge:
- no capture on that edge,
- no done pulse,
- data_out keeps the bits captured so far.
REQ-020 abort in IDLE or DONE SHALL have no effect; if abort and start are both high in IDLE, start SHALL win.
REQ-021 select SHALL keep its last value in IDLE and DONE.
REQ-022 data_out SHALL hold its value from DONE until the next accepted start.
REQ-023 When count_eff=16, every index SHALL be captured exactly once regardless of first_sel.

Reset
REQ-024 reset=1 SHALL immediately force state=IDLE, select=0, data_out=0, busy=0, done=0, remaining=0 and wait counter=0, independent of clk.
REQ-025 Reset asserted mid-scan SHALL discard the scan; after release the block SHALL idle until a new start.

Structure
REQ-026 A shared package mux_scan_pkg SHALL hold:
- the state enum typedef,
- constants SEL_W=4 and N_IN=16,
- the count-normalisation function (0 or >16 maps to 16).
REQ-027 The block SHALL be a single module with no sub-modules; the multiplexer is instantiated beside it at the next level up.

Verification
REQ-028 SETTLE=0, first_sel=0, count=16, bit_in driven by a mux over vector 16'hA5C3 -> select steps 0..15 on consecutive cycles; done 16 edges after start; data_out=16'hA5C3.
REQ-029 SETTLE=2, first_sel=14, count=4, vector 16'hC003 -> select sequence 14,15,0,1, each held 3 cycles; done at edge 12; data_out=16'hC003.
REQ-030 count=0, first_sel=5, SETTLE=0 -> 16 captures wrapping 5..15,0..4; done at edge 16.
REQ-031 abort during the 3rd SAMPLE cycle of a count=8 scan -> no done; busy drops next cycle; data_out holds exactly 2 captured bits; a start in the same cycle as the abort is ignored.
REQ-032 reset pulsed asynchronously between edges mid-scan -> all outputs 0 before the next edge; a later start with count=1 gives done 1 edge after start.

Source files
------------

// File: rtl/mux_scan_sequencer_pkg.sv
// Shared types and helpers for the mux scan sequencer: FSM states, select
// width, input count and the scan-length normalisation.
package mux_scan_pkg;

  localparam int SEL_W = 4;
  localparam int N_IN  = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // A zero or oversize request means a full sweep of all inputs.
  function automatic logic [4:0] norm_count(input logic [4:0] c);
    return (c == 5'd0 || c > 5'd16) ? 5'd16 : c;
  endfunction

endpackage

// File: rtl/mux_scan_sequencer_if.sv
// Scan request/result bundle between a controller, the sequencer and the
// 16:1 bit multiplexer it steers.
interface mux_scan_sequencer_if;
  import mux_scan_pkg::*;

  logic             start;
  logic             abort;
  logic [SEL_W-1:0] first_sel;
  logic [4:0]       count;
  logic             bit_in;
  logic [SEL_W-1:0] select;
  logic             busy;
  logic             done;
  logic [N_IN-1:0]  data_out;

  modport master (
    output start, abort, first_sel, count, bit_in,
    input  select, busy, done, data_out
  );

  modport slave (
    input  start, abort, first_sel, count, bit_in,
    output select, busy, done, data_out
  );

endinterface

// File: rtl/mux_scan_sequencer.sv
// Steps an external 16:1 bit mux through a run of selects, optionally waiting
// SETTLE cycles after each change, and gathers the sampled bits by index.
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int SETTLE = 0
) (
  input logic                 clk,
  input logic                 reset,
  mux_scan_sequencer_if.slave bus
);

  localparam logic [1:0] WAIT_INIT = (SETTLE > 0) ? 2'(SETTLE - 1) : 2'd0;
  localparam state_t     AFTER_SEL = (SETTLE > 0) ? ST_SETTLE : ST_SAMPLE;

  state_t     state;
  logic [4:0] remaining;
  logic [1:0] wait_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      remaining    <= '0;
      wait_cnt     <= '0;
      bus.select   <= '0;
      bus.data_out <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // start beats a simultaneous abort here; abort has no effect in IDLE
          if (bus.start) begin
            bus.select   <= bus.first_sel;
            remaining    <= norm_count(bus.count);
            bus.data_out <= '0;
            wait_cnt     <= WAIT_INIT;
            state        <= AFTER_SEL;
            bus.busy     <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (bus.abort) begin
            state    <= ST_IDLE;
            bus.busy <= 1'b0;
          end else if (wait_cnt == 2'd0) begin
            state <= ST_SAMPLE;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        ST_SAMPLE: begin
          if (bus.abort) begin
            state    <= ST_IDLE;
            bus.busy <= 1'b0;
          end else begin
            bus.data_out[bus.select] <= bus.bit_in;
            bus.select               <= bus.select + 4'd1;
            remaining                <= remaining - 5'd1;
            wait_cnt                 <= WAIT_INIT;
            if (remaining == 5'd1) begin
              state    <= ST_DONE;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
            end else begin
              state <= AFTER_SEL;
            end
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          bus.done <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: two instances (SETTLE=0 and SETTLE=2), each
// with a behavioural mux, checked against a cycle-count/index reference model.
module tb_mux_scan_sequencer;
  import mux_scan_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int tot = 0;
  int bad = 0;

  logic        start_v [2];
  logic        abort_v [2];
  logic [3:0]  first_v [2];
  logic [4:0]  count_v [2];
  logic [15:0] vec_v   [2];

  mux_scan_sequencer_if bus0 ();
  mux_scan_sequencer_if bus2 ();

  assign bus0.start     = start_v[0];
  assign bus0.abort     = abort_v[0];
  assign bus0.first_sel = first_v[0];
  assign bus0.count     = count_v[0];
  assign bus0.bit_in    = vec_v[0][bus0.select];
  assign bus2.start     = start_v[1];
  assign bus2.abort     = abort_v[1];
  assign bus2.first_sel = first_v[1];
  assign bus2.count     = count_v[1];
  assign bus2.bit_in    = vec_v[1][bus2.select];

  mux_scan_sequencer #(.SETTLE(0)) u0 (.clk(clk), .reset(reset), .bus(bus0));
  mux_scan_sequencer #(.SETTLE(2)) u2 (.clk(clk), .reset(reset), .bus(bus2));

  function automatic logic [3:0] o_sel(input int w);
    return (w == 1) ? bus2.select : bus0.select;
  endfunction
  function automatic logic o_busy(input int w);
    return (w == 1) ? bus2.busy : bus0.busy;
  endfunction
  function automatic logic o_done(input int w);
    return (w == 1) ? bus2.done : bus0.done;
  endfunction
  function automatic logic [15:0] o_data(input int w);
    return (w == 1) ? bus2.data_out : bus0.data_out;
  endfunction

  // Expected data: bits at the n indices starting at first (mod 16) copy vec.
  function automatic logic [15:0] model_data(input logic [3:0] first, input int n,
                                             input logic [15:0] vec);
    logic [15:0] d = '0;
    for (int k = 0; k < n; k++) d[(int'(first) + k) % 16] = vec[(int'(first) + k) % 16];
    return d;
  endfunction

  task automatic test_reset();
    #3;
    for (int w = 0; w < 2; w++) begin
      tot++;
      if ({o_sel(w), o_busy(w), o_done(w), o_data(w)} !== 22'd0) begin
        bad++;
        $display("FAIL reset_state[%0d]: got sel=%0h busy=%0b done=%0b data=%0h want all 0",
                 w, o_sel(w), o_busy(w), o_done(w), o_data(w));
      end
    end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  // One full scan on instance w; noise adds start/abort pulses that must be ignored.
  task automatic scan(input int w, input logic [3:0] first, input logic [4:0] cnt,
                      input logic [15:0] vec, input bit noise, input string name);
    int s = (w == 1) ? 2 : 0;
    int n = (cnt == 0 || cnt > 16) ? 16 : int'(cnt);
    int total = n * (s + 1);
    int poke = noise ? int'($urandom_range(1, total)) : 0;
    logic [15:0] exp_d = model_data(first, n, vec);
    logic [3:0] exp_sel;
    @(negedge clk);
    vec_v[w] = vec; first_v[w] = first; count_v[w] = cnt;
    start_v[w] = 1'b1;
    abort_v[w] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    @(negedge clk);
    start_v[w] = 1'b0; abort_v[w] = 1'b0;
    for (int t = 1; t <= total; t++) begin
      exp_sel = 4'((int'(first) + (t - 1) / (s + 1)) % 16);
      tot++;
      if (o_busy(w) !== 1'b1 || o_done(w) !== 1'b0 || o_sel(w) !== exp_sel) begin
        bad++;
        $display("FAIL %s cycle %0d: got busy=%0b done=%0b sel=%0d want busy=1 done=0 sel=%0d",
                 name, t, o_busy(w), o_done(w), o_sel(w), exp_sel);
      end
      start_v[w] = (t == poke);
      if (t == poke) first_v[w] = 4'($urandom);
      @(negedge clk);
    end
    tot++;
    if (o_done(w) !== 1'b1 || o_busy(w) !== 1'b0 || o_data(w) !== exp_d) begin
      bad++;
      $display("FAIL %s done: got done=%0b busy=%0b data=%h want done=1 busy=0 data=%h",
               name, o_done(w), o_busy(w), o_data(w), exp_d);
    end
    start_v[w] = noise;
    abort_v[w] = noise;
    @(negedge clk);
    start_v[w] = 1'b0; abort_v[w] = 1'b0;
    exp_sel = 4'((int'(first) + n) % 16);
    tot++;
    if (o_done(w) !== 1'b0 || o_busy(w) !== 1'b0 || o_data(w) !== exp_d || o_sel(w) !== exp_sel) begin
      bad++;
      $display("FAIL %s idle_hold: got done=%0b busy=%0b data=%h sel=%0d want 0 0 %h %0d",
               name, o_done(w), o_busy(w), o_data(w), o_sel(w), exp_d, exp_sel);
    end
    @(negedge clk);
    tot++;
    if (o_busy(w) !== 1'b0 || o_data(w) !== exp_d) begin
      bad++;
      $display("FAIL %s no_requeue: got busy=%0b data=%h want busy=0 data=%h",
               name, o_busy(w), o_data(w), exp_d);
    end
  endtask

  task automatic test_directed();
    scan(0, 4'd0, 5'd16, 16'hA5C3, 1'b0, "full_sweep");
    scan(1, 4'd14, 5'd4, 16'hC003, 1'b0, "settle_wrap");
    scan(0, 4'd5, 5'd0, 16'h3C96, 1'b0, "count_zero");
    scan(1, 4'd9, 5'd31, 16'h1234, 1'b0, "count_big");
    scan(0, 4'd15, 5'd1, 16'h8000, 1'b0, "single");
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++)
      scan(i % 2, 4'($urandom), 5'($urandom), 16'($urandom), 1'b1, "random");
  endtask

  task automatic test_abort();
    logic [3:0]  first = 4'($urandom);
    logic [15:0] vec = 16'($urandom);
    logic [15:0] exp_d = model_data(first, 2, vec);
    logic [3:0]  exp_sel = first + 4'd2;
    @(negedge clk);
    vec_v[0] = vec; first_v[0] = first; count_v[0] = 5'd8; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    @(negedge clk); @(negedge clk);
    abort_v[0] = 1'b1; start_v[0] = 1'b1; first_v[0] = first + 4'd7;
    @(negedge clk);
    abort_v[0] = 1'b0; start_v[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tot++;
      if (o_busy(0) !== 1'b0 || o_done(0) !== 1'b0 || o_data(0) !== exp_d || o_sel(0) !== exp_sel) begin
        bad++;
        $display("FAIL abort cycle %0d: got busy=%0b done=%0b data=%h sel=%0d want 0 0 %h %0d",
                 c, o_busy(0), o_done(0), o_data(0), o_sel(0), exp_d, exp_sel);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    vec_v[1] = 16'hFFFF; first_v[1] = 4'd3; count_v[1] = 5'd8; start_v[1] = 1'b1;
    @(negedge clk);
    start_v[1] = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    tot++;
    if ({o_sel(1), o_busy(1), o_done(1), o_data(1)} !== 22'd0) begin
      bad++;
      $display("FAIL async_reset: got sel=%0d busy=%0b done=%0b data=%h want all 0",
               o_sel(1), o_busy(1), o_done(1), o_data(1));
    end
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    tot++;
    if (o_busy(1) !== 1'b0 || o_done(1) !== 1'b0 || o_sel(1) !== 4'd0) begin
      bad++;
      $display("FAIL post_reset_idle: got busy=%0b done=%0b sel=%0d want 0 0 0",
               o_busy(1), o_done(1), o_sel(1));
    end
    scan(0, 4'($urandom), 5'd1, 16'($urandom), 1'b0, "post_reset_count1");
  endtask

  initial begin
    for (int w = 0; w < 2; w++) begin
      start_v[w] = 1'b0; abort_v[w] = 1'b0;
      first_v[w] = '0; count_v[w] = '0; vec_v[w] = '0;
    end
    test_reset();
    test_directed();
    test_abort();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
